// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MAR-based RAM access controller.
// Arbitration mode is selected by the MEM_ARB_ROUND_ROBIN_EN macro (see arbiter_2port).
package mem_ctrl_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_DATA  = 1;

    typedef enum logic [1:0] {
        StIdle   = S_IDLE,
        StLoad   = S_LOAD,
        StAccess = S_ACCESS,
        StResp   = S_RESP
    } state_e;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbiter_2port.sv
// Two-port request arbiter holding the priority pointer.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 (fetch) always wins.
module arbiter_2port
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    // ptr_q names the port that wins a simultaneous request
    always_comb begin
        grant = 2'b00;
        if (ptr_q) begin
            if (req[PORT_DATA])       grant = 2'b10;
            else if (req[PORT_FETCH]) grant = 2'b01;
        end else begin
            if (req[PORT_FETCH])      grant = 2'b01;
            else if (req[PORT_DATA])  grant = 2'b10;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (advance && (grant != 2'b00)) ptr_d = grant[PORT_FETCH];
`else
        if (advance) ptr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/memory_access_controller.sv
// Sequences the MAR-based RAM for a fetch port and a data port, one phase per cycle.
// Arbitration policy comes from MEM_ARB_ROUND_ROBIN_EN inside arbiter_2port.
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_set_address,
    output logic              mem_set,
    output logic              mem_enable,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              advance;

    arbiter_2port u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        ack             = 2'b00;
        done            = 2'b00;
        mem_set_address = 1'b0;
        mem_set         = 1'b0;
        mem_enable      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // No grant is issued while reset is held
                if (!reset && (grant != 2'b00)) begin
                    ack     = grant;
                    state_d = StLoad;
                    port_d  = grant[PORT_DATA];
                    we_d    = we[grant[PORT_DATA]];
                    addr_d  = grant[PORT_DATA] ? addr1 : addr0;
                    wdata_d = grant[PORT_DATA] ? wdata1 : wdata0;
                end
            end
            StLoad: begin
                mem_set_address = 1'b1;
                state_d         = StAccess;
            end
            StAccess: begin
                if (we_q) begin
                    mem_set = 1'b1;
                end else begin
                    mem_enable = 1'b1;
                    rdata_d    = mem_data_out;
                end
                state_d = StResp;
            end
            StResp: begin
                done    = port_onehot(port_q);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign advance     = (ack != 2'b00);
    assign busy        = (state_q != StIdle);
    assign mem_address = busy ? addr_q : '0;
    assign mem_data_in = busy ? wdata_q : '0;
    assign rdata       = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed self-checking bench for memory_access_controller with a behavioural MAR RAM.
// Arbitration expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_memory_access_controller;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        ack, done;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_set_address, mem_set, mem_enable;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_controller #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .we              (we),
        .addr0           (addr0),
        .addr1           (addr1),
        .wdata0          (wdata0),
        .wdata1          (wdata1),
        .ack             (ack),
        .done            (done),
        .rdata           (rdata),
        .busy            (busy),
        .mem_address     (mem_address),
        .mem_set_address (mem_set_address),
        .mem_set         (mem_set),
        .mem_enable      (mem_enable),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out)
    );

    // Behavioural RAM: address register loaded by set_address, word array behind it
    logic [DATA_W-1:0] ram [256];
    logic [ADDR_W-1:0] mar;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        mar = '0;
    end

    always @(posedge clk) begin
        if (mem_set_address) mar <= mem_address;
        if (mem_set) ram[mar] <= mem_data_in;
    end

    assign mem_data_out = mem_enable ? ram[mar] : '0;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and report the returned data and ack-to-done latency
    task automatic do_access(input bit p, input bit w, input logic [7:0] a,
                             input logic [15:0] d, output logic [15:0] rd, output int lat);
        int n;
        next_cycle();
        req = p ? 2'b10 : 2'b01;
        we  = w ? 2'b11 : 2'b00;
        if (p) begin addr1 = a; wdata1 = d; end
        else   begin addr0 = a; wdata0 = d; end
        n = 0;
        @(negedge clk);
        while (!ack[p] && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        lat = -1;
        rd  = 'x;
        next_cycle();
        req = 2'b00;
        we  = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done[p] && lat < 0) begin
                lat = c;
                rd  = rdata;
            end
            if (lat < 0) next_cycle();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, done, busy, mem_set_address, mem_set, mem_enable} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b done=%b busy=%b strobes=%b%b%b, want all 0",
                     ack, done, busy, mem_set_address, mem_set, mem_enable);
        end
        checks++;
        if ({rdata, mem_address, mem_data_in} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h din=%h, want 0",
                     rdata, mem_address, mem_data_in);
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ack, done, busy, mem_set_address, mem_set, mem_enable, rdata} !== 25'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ack=%b done=%b busy=%b rdata=%h, want 0",
                     ack, done, busy, rdata);
        end
    endtask

    task automatic test_write_read;
        next_cycle();
        req = 2'b10; we = 2'b10; addr1 = 8'h3A; wdata1 = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({ack, busy} !== 3'b100) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b busy=%b, want 10/0", ack, busy);
        end
        next_cycle();
        req = 2'b00; we = 2'b00;
        @(negedge clk);
        checks++;
        if ({mem_set_address, mem_set, mem_enable, mem_address, busy} !== {3'b100, 8'h3A, 1'b1}) begin
            errors++;
            $display("FAIL wr_load: got strobes=%b%b%b addr=%h, want 100/3a",
                     mem_set_address, mem_set, mem_enable, mem_address);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_set_address, mem_set, mem_enable, mem_data_in} !== {3'b010, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_access: got strobes=%b%b%b din=%h, want 010/beef",
                     mem_set_address, mem_set, mem_enable, mem_data_in);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({done, mem_set_address, mem_set, mem_enable, rdata} !== {5'b10000, 16'h0}) begin
            errors++;
            $display("FAIL wr_done: got done=%b rdata=%h, want 10/0000", done, rdata);
        end
        next_cycle();
        req = 2'b10; we = 2'b00; addr1 = 8'h3A;
        @(negedge clk);
        checks++;
        if ({ack, busy, done} !== 5'b10000) begin
            errors++;
            $display("FAIL rd_ack: got ack=%b busy=%b done=%b, want 10/0/00", ack, busy, done);
        end
        next_cycle();
        req = 2'b00;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_set_address, mem_set, mem_enable} !== 3'b001) begin
            errors++;
            $display("FAIL rd_access: got strobes=%b%b%b, want 001",
                     mem_set_address, mem_set, mem_enable);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({done, rdata} !== {2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_done: got done=%b rdata=%h, want 10/beef", done, rdata);
        end
    endtask

    task automatic test_arbitration;
        logic [1:0] g [4];
        int         cyc [4];
        int         n;
        logic [1:0] exp_g;
        n = 0;
        next_cycle();
        req = 2'b11; we = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                g[n]   = ack;
                cyc[n] = c;
                n++;
            end
            next_cycle();
        end
        req = 2'b00;
        repeat (4) next_cycle();
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arb_count: got %0d grants, want 4", n);
        end
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++;
            if (g[i] !== exp_g) begin
                errors++;
                $display("FAIL arb_grant%0d: got ack=%b, want %b", i, g[i], exp_g);
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] != 4) begin
                    errors++;
                    $display("FAIL arb_spacing%0d: got %0d cycles, want 4", i, cyc[i] - cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_withdrawal;
        bit bad;
        next_cycle();
        req = 2'b10; we = 2'b00; addr1 = 8'h3A;
        @(negedge clk);
        checks++;
        if (ack !== 2'b10) begin
            errors++;
            $display("FAIL wd_ack: got ack=%b, want 10", ack);
        end
        next_cycle();
        req = 2'b01; addr0 = 8'h55;
        @(negedge clk);
        checks++;
        if ({ack, mem_set_address} !== 3'b001) begin
            errors++;
            $display("FAIL wd_load: got ack=%b sa=%b, want 00/1", ack, mem_set_address);
        end
        next_cycle();
        req = 2'b00;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({done, ack, rdata} !== {4'b1000, 16'hBEEF}) begin
            errors++;
            $display("FAIL wd_done: got done=%b ack=%b rdata=%h, want 10/00/beef", done, ack, rdata);
        end
        bad = 1'b0;
        repeat (4) begin
            next_cycle();
            @(negedge clk);
            if (ack != 2'b00 || busy || done != 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wd_no_extra: got extra activity=%b, want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        int          lat;
        bit          bad;
        next_cycle();
        req = 2'b01; we = 2'b01; addr0 = 8'hFF; wdata0 = 16'h1234;
        @(negedge clk);
        checks++;
        if (ack !== 2'b01) begin
            errors++;
            $display("FAIL rm_ack: got ack=%b, want 01", ack);
        end
        next_cycle();
        req = 2'b00; we = 2'b00;
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_set !== 1'b1) begin
            errors++;
            $display("FAIL rm_access: got mem_set=%b, want 1", mem_set);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, ack, mem_set_address, mem_set, mem_enable, mem_address, rdata} !== 32'h0) begin
            errors++;
            $display("FAIL rm_idle: got busy=%b done=%b strobes=%b%b%b addr=%h rdata=%h, want 0",
                     busy, done, mem_set_address, mem_set, mem_enable, mem_address, rdata);
        end
        bad = 1'b0;
        repeat (4) begin
            next_cycle();
            @(negedge clk);
            if (done != 2'b00 || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rm_no_done: got stray done/busy=%b, want 0", bad);
        end
        do_access(1'b0, 1'b1, 8'hFF, 16'hCAFE, rd, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL rm_wr_latency: got %0d, want 3", lat);
        end
        do_access(1'b0, 1'b0, 8'hFF, 16'h0000, rd, lat);
        checks++;
        if (lat != 3 || rd !== 16'hCAFE) begin
            errors++;
            $display("FAIL rm_readback: got lat=%0d rdata=%h, want 3/cafe", lat, rd);
        end
    endtask

    task automatic test_random;
        int grants;
        bit viol;
        grants = 0;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            req    = 2'($urandom_range(0, 3));
            we     = 2'($urandom_range(0, 3));
            addr0  = 8'($urandom);
            addr1  = 8'($urandom);
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            @(negedge clk);
            viol = ((32'(mem_set_address) + 32'(mem_set) + 32'(mem_enable)) > 1)
                   || !$onehot0(ack) || !$onehot0(done) || (ack != 2'b00 && busy)
                   || (!busy && {mem_set_address, mem_set, mem_enable} != 3'b000);
            if (ack != 2'b00) grants++;
            checks++;
            if (viol) begin
                errors++;
                $display("FAIL rand_strobes cycle %0d: got ack=%b done=%b busy=%b strobes=%b%b%b",
                         i, ack, done, busy, mem_set_address, mem_set, mem_enable);
            end
        end
        req = 2'b00;
        repeat (4) next_cycle();
        checks++;
        if (grants < 20) begin
            errors++;
            $display("FAIL rand_progress: got %0d grants, want at least 20", grants);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_withdrawal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
